// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the ysyx_24110006 core: widths, reset PC and
// write-back stage state encodings.
package ysyx_24110006_pkg;

  localparam int XLEN   = 32;
  localparam int GPR_AW = 5;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_NPC  = 2'd2
  } wbu_state_e;

  // Sequential PC wraps modulo 2^32, so 32'hFFFF_FFFC falls through to 0.
  function automatic logic [XLEN-1:0] calc_npc(
    input logic            jump,
    input logic [XLEN-1:0] pc,
    input logic [XLEN-1:0] upc
  );
    logic [XLEN-1:0] w_seq;
    w_seq = pc + 32'd4;
    return jump ? upc : w_seq;
  endfunction

endpackage

// File: rtl/wbu_commit.sv
// Write-back/commit stage: accepts one executed instruction, pulses GPR/CSR
// writes and a retire strobe, then offers the next PC to the IFU.
module wbu_commit
  import ysyx_24110006_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              CNT_W    = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_upc,
  input  logic              i_jump,
  input  logic [XLEN-1:0]   i_result,
  input  logic [XLEN-1:0]   i_csr_rdata,
  input  logic              i_result_t,
  input  logic              i_reg_wen,
  input  logic [GPR_AW-1:0] i_reg_rd,
  input  logic              i_csr_wen,
  output logic              o_rf_wen,
  output logic [GPR_AW-1:0] o_rf_waddr,
  output logic [XLEN-1:0]   o_rf_wdata,
  output logic              o_csr_wen,
  output logic [XLEN-1:0]   o_csr_wdata,
  output logic              o_npc_valid,
  input  logic              i_npc_ready,
  output logic [XLEN-1:0]   o_npc,
  output logic              o_commit,
  output logic [CNT_W-1:0]  o_inst_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wbu_state_e       r_state;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_upc;
  logic             r_jump;

  assign o_ready = (r_state == ST_IDLE);

  // Commit FSM; GPR/CSR data are captured straight into their output registers
  // at acceptance so they are valid throughout WB and hold afterwards.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_upc       <= '0;
      r_jump      <= 1'b0;
      o_rf_wen    <= 1'b0;
      o_rf_waddr  <= '0;
      o_rf_wdata  <= '0;
      o_csr_wen   <= 1'b0;
      o_csr_wdata <= '0;
      o_npc_valid <= 1'b0;
      o_npc       <= RESET_PC;
      o_commit    <= 1'b0;
      o_inst_cnt  <= '0;
    end else begin
      o_rf_wen  <= 1'b0;
      o_csr_wen <= 1'b0;
      o_commit  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid) begin
            r_pc        <= i_pc;
            r_upc       <= i_upc;
            r_jump      <= i_jump;
            o_rf_wen    <= i_reg_wen && (i_reg_rd != 5'd0);
            o_rf_waddr  <= i_reg_rd;
            o_rf_wdata  <= i_result_t ? i_csr_rdata : i_result;
            o_csr_wen   <= i_csr_wen;
            o_csr_wdata <= i_result;
            o_commit    <= 1'b1;
            r_state     <= ST_WB;
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_WB: begin
          o_npc       <= calc_npc(r_jump, r_pc, r_upc);
          o_npc_valid <= 1'b1;
          o_inst_cnt  <= o_inst_cnt + CNT_ONE;
          r_state     <= ST_NPC;
        end
        ST_NPC: begin
          if (i_npc_ready) begin
            o_npc_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_state     <= ST_NPC;
          end
        end
        default: begin
          o_npc_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wbu_commit.md
Name: wbu_commit

Overview:
- Write-back/commit stage of the ysyx_24110006 core; consumer end of the execute-stage valid/ready interface.
- Accepts one executed instruction at a time, writes GPR and CSR, then hands the next PC to the IFU over a second valid/ready handshake.
- Also keeps a retired-instruction counter for perf and difftest.

Parameters:
- RESET_PC, 32'h8000_0000, value of o_npc after reset.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- i_clock  in  1  clock; all state on rising edge
- i_reset  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_valid  in  1  upstream has an instruction
- o_ready  out  1  block can accept; high only in IDLE
- i_pc  in  32  PC of the incoming instruction
- i_upc  in  32  jump/branch/trap target
- i_jump  in  1  take i_upc as next PC
- i_result  in  32  ALU/LSU result
- i_csr_rdata  in  32  old CSR value (csrr*)
- i_result_t  in  1  0: rd <= i_result; 1: rd <= i_csr_rdata
- i_reg_wen  in  1  instruction writes rd
- i_reg_rd  in  5  destination register
- i_csr_wen  in  1  instruction writes CSR
- o_rf_wen  out  1  GPR write strobe
- o_rf_waddr  out  5  GPR address
- o_rf_wdata  out  32  GPR data
- o_csr_wen  out  1  CSR write strobe
- o_csr_wdata  out  32  CSR data (= latched i_result)
- o_npc_valid  out  1  next PC offered to IFU
- i_npc_ready  in  1  IFU takes next PC
- o_npc  out  32  next PC
- o_commit  out  1  one-cycle retire pulse
- o_inst_cnt  out  CNT_W  retired-instruction count

Behaviour:
- FSM states: IDLE, WB, NPC.
  - IDLE -> WB when i_valid && o_ready.
  - WB -> NPC unconditionally, after 1 cycle.
  - NPC -> IDLE when i_npc_ready.
- Reset (i_reset=0, async):
  - State goes to IDLE.
  - o_rf_wen = o_csr_wen = o_commit = o_npc_valid = 0.
  - o_npc = RESET_PC; o_inst_cnt = 0.
  - Latched fields are don't-care.
  - Reset mid-operation abandons the instruction: no write, no commit.
- Accept: on the IDLE handshake edge, latch pc, upc, jump, result, csr_rdata, result_t, reg_wen, rd, csr_wen.
- o_ready = (state==IDLE), combinational from state. i_valid outside IDLE is ignored and upstream must hold it.
- WB cycle (handshake edge + 1):
  - o_rf_wen = reg_wen && rd!=0; x0 writes are always suppressed.
  - o_rf_waddr = rd; o_rf_wdata = result_t ? csr_rdata : result.
  - o_csr_wen = csr_wen; o_csr_wdata = result.
  - o_commit = 1; o_inst_cnt increments at the end of WB, modulo 2^CNT_W (wraps to 0).
  - Strobes are 0 in all other states. o_rf_waddr/o_rf_wdata/o_csr_wdata hold their last value.
- NPC computation: o_npc = jump ? upc : pc + 4, mod 2^32 (32'hFFFF_FFFC + 4 -> 0). Registered when leaving WB, held until the next one.
- NPC state:
  - o_npc_valid = 1; o_npc is stable while valid.
  - If i_npc_ready is already high on entry, the handshake completes in the first NPC cycle.
  - o_npc_valid drops the cycle after the handshake.
- Latency: handshake at edge T; write strobes during cycle T+1; o_npc_valid from T+2. Minimum issue interval is 3 cycles.
- i_npc_ready in IDLE/WB is ignored.

Decomposition:
- Shared package ysyx_24110006_pkg holds:
  - state encodings (IDLE=2'd0, WB=2'd1, NPC=2'd2);
  - RESET_PC default;
  - GPR address width 5 and XLEN 32.
- No sub-module; the FSM, latches and npc adder fit in one file.

Test Plan:
- Reset then release, no stimulus -> o_npc=32'h8000_0000, o_npc_valid=0, o_ready=1, o_inst_cnt=0.
- Non-jump ALU op, pc=32'h8000_0010, rd=5, result=32'h1234, reg_wen=1 -> next cycle o_rf_wen=1, waddr=5, wdata=32'h1234, o_commit=1; then o_npc=32'h8000_0014, valid until i_npc_ready; o_inst_cnt=1.
- rd=0 with reg_wen=1 -> o_rf_wen stays 0, o_commit still pulses; csrrw with result_t=1, csr_rdata=32'hABCD, result=32'h5 -> rf wdata=32'hABCD, o_csr_wen=1, csr_wdata=32'h5.
- jump=1, upc=32'h8000_0100 with i_npc_ready held 0 for 4 cycles -> o_npc=32'h8000_0100 stable, o_ready=0, a second i_valid is not accepted until after the npc handshake.
- pc=32'hFFFF_FFFC non-jump -> o_npc=0; preload counter at all-ones (CNT_W=8 build) -> wraps to 0.
- Assert i_reset=0 asynchronously during WB -> strobes drop immediately, o_inst_cnt=0, o_npc=RESET_PC, state IDLE.
